// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: core LSU (M0) and debug/DMA loader (M1).
// Each cycle it grants at most one master and routes that master's address,
// write data and write enable to the single-port memory. Read data comes back
// registered to the granted master. A locking master keeps ownership, but the
// hold counter bounds the lock so a waiting master cannot starve.
module dmem_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic              M0_LOCK,
    input  logic [DATA_W-1:0] M0_A,
    input  logic [DATA_W-1:0] M0_WD,
    output logic              M0_GNT,
    output logic              M0_RVALID,
    output logic [DATA_W-1:0] M0_RD,
    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic              M1_LOCK,
    input  logic [DATA_W-1:0] M1_A,
    input  logic [DATA_W-1:0] M1_WD,
    output logic              M1_GNT,
    output logic              M1_RVALID,
    output logic [DATA_W-1:0] M1_RD,
    output logic [DATA_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_WD,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RD
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state, state_n;
    logic       ptr, ptr_n;
    logic [7:0] hold, hold_n;
    logic       g0, g1;
    logic       idle_g0, idle_g1;
    logic [7:0] hold_inc;

    // Grant selection; everything is held off while reset is asserted
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        // Resolution used when no one owns the memory (or the owner dropped REQ)
        idle_g0 = M0_REQ & (~M1_REQ | ~ptr);
        idle_g1 = M1_REQ & (~M0_REQ |  ptr);
        unique case (state)
            OWN0: begin
                if (M0_REQ) begin
                    if ((hold == HOLD_MAX) && M1_REQ) g1 = 1'b1;
                    else                              g0 = 1'b1;
                end else begin
                    g0 = idle_g0;
                    g1 = idle_g1;
                end
            end
            OWN1: begin
                if (M1_REQ) begin
                    if ((hold == HOLD_MAX) && M0_REQ) g0 = 1'b1;
                    else                              g1 = 1'b1;
                end else begin
                    g0 = idle_g0;
                    g1 = idle_g1;
                end
            end
            default: begin
                g0 = idle_g0;
                g1 = idle_g1;
            end
        endcase
        if (!RST_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    // Memory-side mux driven by whichever master is granted
    always_comb begin
        M0_GNT = g0;
        M1_GNT = g1;
        MEM_A  = '0;
        MEM_WD = '0;
        MEM_WE = 1'b0;
        if (g0) begin
            MEM_A  = M0_A;
            MEM_WD = M0_WD;
            MEM_WE = M0_WE;
        end else if (g1) begin
            MEM_A  = M1_A;
            MEM_WD = M1_WD;
            MEM_WE = M1_WE;
        end
    end

    // Next state, round-robin pointer and saturating hold count
    always_comb begin
        state_n  = IDLE;
        ptr_n    = ptr;
        hold_n   = '0;
        hold_inc = (hold == HOLD_MAX) ? hold : hold + 8'd1;
        if (g0) begin
            ptr_n   = 1'b1;
            state_n = M0_LOCK ? OWN0 : IDLE;
            hold_n  = (state == OWN0) ? hold_inc : 8'd1;
        end else if (g1) begin
            ptr_n   = 1'b0;
            state_n = M1_LOCK ? OWN1 : IDLE;
            hold_n  = (state == OWN1) ? hold_inc : 8'd1;
        end
    end

    // Arbitration state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hold  <= hold_n;
        end
    end

    // Read return: capture memory data for the master granted a read
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            M0_RVALID <= 1'b0;
            M1_RVALID <= 1'b0;
            M0_RD     <= '0;
            M1_RD     <= '0;
        end else begin
            M0_RVALID <= g0 & ~M0_WE;
            M1_RVALID <= g1 & ~M1_WE;
            if (g0 && !M0_WE) M0_RD <= MEM_RD;
            if (g1 && !M1_WE) M1_RD <= MEM_RD;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RST_n;
    logic        M0_REQ, M0_WE, M0_LOCK;
    logic [31:0] M0_A, M0_WD;
    logic        M0_GNT, M0_RVALID;
    logic [31:0] M0_RD;
    logic        M1_REQ, M1_WE, M1_LOCK;
    logic [31:0] M1_A, M1_WD;
    logic        M1_GNT, M1_RVALID;
    logic [31:0] M1_RD;
    logic [31:0] MEM_A, MEM_WD, MEM_RD;
    logic        MEM_WE;

    logic [31:0] mem [0:63];

    int unsigned n_vec;
    int unsigned n_err;

    dmem_arbiter #(.DATA_W(32), .MAX_HOLD(8)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_LOCK(M0_LOCK), .M0_A(M0_A), .M0_WD(M0_WD),
        .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RD(M0_RD),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_LOCK(M1_LOCK), .M1_A(M1_A), .M1_WD(M1_WD),
        .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RD(M1_RD),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port memory: synchronous write, combinational read
    always @(posedge CLK) if (MEM_WE) mem[MEM_A[7:2]] <= MEM_WD;
    assign MEM_RD = mem[MEM_A[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        M0_REQ = 0; M0_WE = 0; M0_LOCK = 0; M0_A = '0; M0_WD = '0;
        M1_REQ = 0; M1_WE = 0; M1_LOCK = 0; M1_A = '0; M1_WD = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        idle_inputs();
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_m0_gnt", {31'd0, M0_GNT}, 32'd0);
        chk("rst_m1_gnt", {31'd0, M1_GNT}, 32'd0);
        chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        chk("rst_m0_rvalid", {31'd0, M0_RVALID}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, M1_RVALID}, 32'd0);
        chk("rst_m0_rd", M0_RD, 32'd0);
        chk("rst_m1_rd", M1_RD, 32'd0);

        // Write then read, M0 only
        do_reset();
        M0_REQ = 1; M0_WE = 1; M0_A = 32'h10; M0_WD = 32'hDEADBEEF;
        @(negedge CLK);
        chk("wr_m0_gnt", {31'd0, M0_GNT}, 32'd1);
        chk("wr_m1_gnt", {31'd0, M1_GNT}, 32'd0);
        chk("wr_mem_we", {31'd0, MEM_WE}, 32'd1);
        chk("wr_mem_a", MEM_A, 32'h10);
        chk("wr_mem_wd", MEM_WD, 32'hDEADBEEF);
        step();
        M0_WE = 0;
        @(negedge CLK);
        chk("rd_m0_gnt", {31'd0, M0_GNT}, 32'd1);
        chk("rd_mem_we", {31'd0, MEM_WE}, 32'd0);
        chk("wr_no_rvalid", {31'd0, M0_RVALID}, 32'd0);
        step();
        M0_REQ = 0;
        chk("rd_rvalid", {31'd0, M0_RVALID}, 32'd1);
        chk("rd_data", M0_RD, 32'hDEADBEEF);
        step();
        chk("rd_rvalid_pulse", {31'd0, M0_RVALID}, 32'd0);
        chk("rd_data_hold", M0_RD, 32'hDEADBEEF);

        // Round-robin, no lock
        do_reset();
        M0_REQ = 1; M0_A = 32'h10; M1_REQ = 1; M1_A = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("rr_m0_gnt[%0d]", i), {31'd0, M0_GNT}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_m1_gnt[%0d]", i), {31'd0, M1_GNT}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
        end
        idle_inputs();

        // Forced release after MAX_HOLD grants
        do_reset();
        M0_REQ = 1; M0_LOCK = 1; M1_REQ = 1;
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            chk($sformatf("fr_m0_gnt[%0d]", i), {31'd0, M0_GNT},
                (i == 8 || i == 17) ? 32'd0 : 32'd1);
            chk($sformatf("fr_m1_gnt[%0d]", i), {31'd0, M1_GNT},
                (i == 8 || i == 17) ? 32'd1 : 32'd0);
            step();
        end
        idle_inputs();

        // Saturated lock, then M1 arrives
        do_reset();
        M0_REQ = 1; M0_LOCK = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0 || i == 9 || i == 19)
                chk($sformatf("sat_m0_gnt[%0d]", i), {31'd0, M0_GNT}, 32'd1);
            step();
        end
        M1_REQ = 1;
        @(negedge CLK);
        chk("sat_m1_first", {31'd0, M1_GNT}, 32'd1);
        chk("sat_m0_off", {31'd0, M0_GNT}, 32'd0);
        step();
        @(negedge CLK);
        chk("sat_m0_back", {31'd0, M0_GNT}, 32'd1);
        chk("sat_m1_off", {31'd0, M1_GNT}, 32'd0);
        step();
        idle_inputs();

        // Reset mid-write by M1
        do_reset();
        M1_REQ = 1; M1_WE = 1; M1_A = 32'h20; M1_WD = 32'hA5A5A5A5;
        step();
        M1_WD = 32'h12345678;
        @(negedge CLK);
        chk("rw_m1_gnt", {31'd0, M1_GNT}, 32'd1);
        chk("rw_mem_we", {31'd0, MEM_WE}, 32'd1);
        #2;
        RST_n = 1'b0;
        #1;
        chk("rw_we_drop", {31'd0, MEM_WE}, 32'd0);
        chk("rw_gnt_drop", {31'd0, M1_GNT}, 32'd0);
        chk("rw_a_zero", MEM_A, 32'd0);
        chk("rw_wd_zero", MEM_WD, 32'd0);
        step();
        chk("rw_mem_kept", mem[8], 32'hA5A5A5A5);
        chk("rw_rvalid", {31'd0, M1_RVALID}, 32'd0);
        chk("rw_rd", M1_RD, 32'd0);
        @(negedge CLK);
        M1_WE = 0;
        M0_REQ = 1; M0_WE = 0; M0_A = 32'h20;
        RST_n = 1'b1;
        #1;
        chk("rw_ptr0_m0", {31'd0, M0_GNT}, 32'd1);
        chk("rw_ptr0_m1", {31'd0, M1_GNT}, 32'd0);
        step();
        chk("rw_readback_v", {31'd0, M0_RVALID}, 32'd1);
        chk("rw_readback", M0_RD, 32'hA5A5A5A5);
        idle_inputs();

        // Mixed traffic: M0 write and M1 read together
        do_reset();
        M0_REQ = 1; M0_WE = 1; M0_A = 32'h14; M0_WD = 32'hCAFEF00D;
        M1_REQ = 1; M1_WE = 0; M1_A = 32'h10;
        @(negedge CLK);
        chk("mx_m0_gnt", {31'd0, M0_GNT}, 32'd1);
        chk("mx_m1_wait", {31'd0, M1_GNT}, 32'd0);
        chk("mx_mem_a0", MEM_A, 32'h14);
        step();
        M0_REQ = 0; M0_WE = 0;
        chk("mx_no_rv0", {31'd0, M0_RVALID}, 32'd0);
        chk("mx_no_rv1", {31'd0, M1_RVALID}, 32'd0);
        @(negedge CLK);
        chk("mx_m1_gnt", {31'd0, M1_GNT}, 32'd1);
        chk("mx_mem_a1", MEM_A, 32'h10);
        chk("mx_mem_we1", {31'd0, MEM_WE}, 32'd0);
        step();
        M1_REQ = 0;
        chk("mx_m1_rvalid", {31'd0, M1_RVALID}, 32'd1);
        chk("mx_m1_rd", M1_RD, 32'hDEADBEEF);
        chk("mx_m0_rvalid", {31'd0, M0_RVALID}, 32'd0);
        chk("mx_m0_rd", M0_RD, 32'd0);
        chk("mx_mem_wr", mem[5], 32'hCAFEF00D);
        step();
        chk("mx_m1_rv_pulse", {31'd0, M1_RVALID}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
